// File: rtl/dance_pkg.sv
// Shared definitions for the dance game: flow states and pad bit positions.
// The renderer and the gameplay engine import this package as well.
package dance_pkg;

  typedef enum logic [2:0] {
    ST_MAIN     = 3'd0,
    ST_DIFF_SEL = 3'd1,
    ST_SONG_SEL = 3'd2,
    ST_GAMEPLAY = 3'd3,
    ST_PAUSED   = 3'd4,
    ST_RESULTS  = 3'd5
  } flow_state_t;

  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;

endpackage

// File: rtl/menu_flow_ctrl_wrap_sel.sv
// Modular selection index 0..N-1 stepped by single-cycle inc/dec strobes.
// The index is held whenever en is low.
module wrap_sel #(
  parameter int N = 3,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] idx
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] idx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= '0;
    end else if (en && dec) begin
      idx_q <= (idx_q == '0) ? LAST : idx_q - 1'b1;
    end else if (en && inc) begin
      idx_q <= (idx_q == LAST) ? '0 : idx_q + 1'b1;
    end
  end

  assign idx = idx_q;

endmodule

// File: rtl/menu_flow_ctrl.sv
// Game-flow controller: menu -> difficulty -> song -> gameplay/pause -> results.
// Acts on pad press edges with priority up > down > left > right.
module menu_flow_ctrl
  import dance_pkg::*;
#(
  parameter int N_DIFF      = 3,
  parameter int N_SONGS     = 3,
  parameter int IDX_W       = 4,
  parameter int TIMEOUT_CYC = 500_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       btn,
  input  logic             game_over,
  output logic [2:0]       state,
  output logic [IDX_W-1:0] diff_idx,
  output logic [IDX_W-1:0] song_idx,
  output logic             game_en,
  output logic             game_start,
  output logic             game_abort
);

  localparam int TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [TW-1:0] T_LAST = (TIMEOUT_CYC > 0) ? TW'(TIMEOUT_CYC - 1) : '0;

  flow_state_t   state_q;
  logic [3:0]    btn_q;
  logic [3:0]    press;
  logic [TW-1:0] timer_q;
  logic          game_en_q, game_start_q, game_abort_q;
  logic          p_up, p_down, p_left, p_right, any_press, timeout_hit;

  // One-hot resolution of simultaneous presses.
  always_comb begin
    press       = btn & ~btn_q;
    p_up        = press[BTN_UP];
    p_down      = press[BTN_DOWN] & ~press[BTN_UP];
    p_left      = press[BTN_LEFT] & ~press[BTN_UP] & ~press[BTN_DOWN];
    p_right     = press[BTN_RIGHT] & ~press[BTN_UP] & ~press[BTN_DOWN] & ~press[BTN_LEFT];
    any_press   = |press;
    timeout_hit = (TIMEOUT_CYC != 0) && (timer_q == T_LAST) && !any_press;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_MAIN;
      btn_q        <= '0;
      timer_q      <= '0;
      game_en_q    <= 1'b0;
      game_start_q <= 1'b0;
      game_abort_q <= 1'b0;
    end else begin
      btn_q        <= btn;
      timer_q      <= '0;
      game_en_q    <= 1'b0;
      game_start_q <= 1'b0;
      game_abort_q <= 1'b0;
      case (state_q)
        ST_MAIN: begin
          if (any_press) state_q <= ST_DIFF_SEL;
        end
        ST_DIFF_SEL: begin
          if (p_down)                             state_q <= ST_SONG_SEL;
          else if (p_up)                          state_q <= ST_MAIN;
          else if (timeout_hit)                   state_q <= ST_MAIN;
          else if (!any_press && TIMEOUT_CYC != 0) timer_q <= timer_q + 1'b1;
        end
        ST_SONG_SEL: begin
          if (p_down) begin
            state_q      <= ST_GAMEPLAY;
            game_en_q    <= 1'b1;
            game_start_q <= 1'b1;
          end else if (p_up)                      state_q <= ST_DIFF_SEL;
          else if (timeout_hit)                   state_q <= ST_MAIN;
          else if (!any_press && TIMEOUT_CYC != 0) timer_q <= timer_q + 1'b1;
        end
        ST_GAMEPLAY: begin
          // End of song outranks a pause request in the same cycle.
          if (game_over)  state_q <= ST_RESULTS;
          else if (p_up)  state_q <= ST_PAUSED;
          else            game_en_q <= 1'b1;
        end
        ST_PAUSED: begin
          if (p_down) begin
            state_q   <= ST_GAMEPLAY;
            game_en_q <= 1'b1;
          end else if (p_up) begin
            state_q      <= ST_SONG_SEL;
            game_abort_q <= 1'b1;
          end
        end
        ST_RESULTS: begin
          if (any_press) state_q <= ST_SONG_SEL;
        end
        default: state_q <= ST_MAIN;
      endcase
    end
  end

  wrap_sel #(.N(N_DIFF), .W(IDX_W)) u_diff_sel (
    .clk (clk),
    .rst (rst),
    .en  (state_q == ST_DIFF_SEL),
    .inc (p_right),
    .dec (p_left),
    .idx (diff_idx)
  );

  wrap_sel #(.N(N_SONGS), .W(IDX_W)) u_song_sel (
    .clk (clk),
    .rst (rst),
    .en  (state_q == ST_SONG_SEL),
    .inc (p_right),
    .dec (p_left),
    .idx (song_idx)
  );

  assign state      = state_q;
  assign game_en    = game_en_q;
  assign game_start = game_start_q;
  assign game_abort = game_abort_q;

endmodule

// File: doc/menu_flow_ctrl.md
# menu_flow_ctrl

Top-level game-flow controller for the dance game, driven by the four direction pads. It walks the player through main menu, difficulty select, song select, gameplay, pause and results screens. The number of difficulties and songs is parametrised, with wrap-around selection, an idle timeout and pause/abort. Its index and enable outputs feed the renderer and the gameplay engine.

## Interface
- `N_DIFF`, default 3: number of selectable difficulties; must be ≥2.
- `N_SONGS`, default 3: number of selectable songs; must be ≥2.
- `IDX_W`, default 4: width of `diff_idx` and `song_idx`; must satisfy 2^IDX_W ≥ max(`N_DIFF`, `N_SONGS`).
- `TIMEOUT_CYC`, default 500_000_000: idle cycles before a selector screen falls back to MAIN; 0 disables the timeout.
- `clk` input 1: system clock.
- `rst` input 1: asynchronous, active-high reset.
- `btn` input 4: pad levels as {right, left, down, up}; already synchronised and debounced upstream.
- `game_over` input 1: level from the gameplay engine, sampled only in GAMEPLAY.
- `state` output 3: current state encoding.
- `diff_idx` output IDX_W: selected difficulty, range 0..N_DIFF-1.
- `song_idx` output IDX_W: selected song, range 0..N_SONGS-1.
- `game_en` output 1: high while in GAMEPLAY.
- `game_start` output 1: one-cycle pulse on entry to GAMEPLAY from SONG_SEL.
- `game_abort` output 1: one-cycle pulse on PAUSED→SONG_SEL.

## Operation
- **Edge detection.** `btn_q` registers `btn`; `press = btn & ~btn_q`. Only presses act, so a held button fires once.
- **Press priority.** When several presses occur in one cycle, only the highest priority acts: up > down > left > right.
- **State encodings:** MAIN=0, DIFF_SEL=1, SONG_SEL=2, GAMEPLAY=3, PAUSED=4, RESULTS=5. Codes 6–7 are illegal and recover to MAIN on the next edge.
- **MAIN:** any press → DIFF_SEL.
- **DIFF_SEL:**
  - left: `diff_idx` − 1, wrapping 0 → N_DIFF−1.
  - right: `diff_idx` + 1, wrapping N_DIFF−1 → 0.
  - down → SONG_SEL.
  - up → MAIN.
- **SONG_SEL:**
  - left/right: same wrap rules applied to `song_idx` with N_SONGS.
  - down → GAMEPLAY, and pulse `game_start`.
  - up → DIFF_SEL.
- **GAMEPLAY:**
  - `game_over`=1 → RESULTS. This has priority over any press in the same cycle.
  - otherwise, up → PAUSED.
  - all other presses are ignored; the gameplay engine consumes them.
- **PAUSED:**
  - down → GAMEPLAY. No `game_start` pulse; this is a resume.
  - up → SONG_SEL, and pulse `game_abort`.
  - `game_over` is ignored.
- **RESULTS:** any press → SONG_SEL.
- **Index retention.** `diff_idx` and `song_idx` hold their values in every state other than their own selector. Returning to a selector shows the previous choice.
- **Idle timer.** A counter of width clog2(TIMEOUT_CYC+1) runs only in DIFF_SEL and SONG_SEL.
  - It clears on any press, on any state change, and in all other states.
  - When it reaches TIMEOUT_CYC−1 with no press that cycle, the next edge goes to MAIN. Indices are kept.

## Timing
- **Reset values (asynchronous):**
  - `state`=MAIN, `diff_idx`=0, `song_idx`=0.
  - `game_en`=0, `game_start`=0, `game_abort`=0.
  - `btn_q`=0 and timer=0.
- A button held through reset release therefore registers as a press on the first edge.
- All outputs are registered.
- A press that is high at rising edge k takes effect at edge k: the new `state` or index is visible after edge k. This is a one-cycle response from the input level.
- `game_start` and `game_abort` are high for exactly the one cycle following the transition edge.
- `game_en` rises in the same cycle as `game_start` and falls in the cycle after the GAMEPLAY→RESULTS or GAMEPLAY→PAUSED edge.
- **Reset mid-operation:** asserting `rst` in GAMEPLAY or PAUSED drops `game_en` immediately (asynchronously) and returns to MAIN. No `game_abort` pulse is produced.
- **Press on the timeout cycle:** the press wins and the timer clears.

## Structure
- Shared package `dance_pkg` holds:
  - the state enum `flow_state_t` (3 bits);
  - button bit-position constants BTN_UP=0, BTN_DOWN=1, BTN_LEFT=2, BTN_RIGHT=3.
  - The renderer and gameplay engine import the same package.
- One sub-module, `wrap_sel`, is parametrised on N and W. It has inputs inc, dec and en, and holds a modular index register. It is instantiated twice: once for difficulty, once for song.
- Edge detection, priority encoding, the FSM and the idle timer all live in `menu_flow_ctrl`.

## Test plan
- **Reset and held press:** hold `btn`=4'b0001 through reset release → `state`=DIFF_SEL after the first edge; holding longer produces no further transitions.
- **Difficulty wrap:** in DIFF_SEL with N_DIFF=3, press left from 0 → `diff_idx`=2; press right ×2 → 1. Simultaneous left+right → only left acts, giving 0.
- **Full flow:** DIFF 2 → down → SONG_SEL; right → `song_idx`=1; down → `game_start` pulses exactly 1 cycle and `game_en`=1. Then `game_over`=1 with up pressed in the same cycle → RESULTS, not PAUSED. Any press → SONG_SEL with `song_idx` still 1 and `diff_idx` still 2.
- **Pause, resume and abort:** GAMEPLAY, up → PAUSED with `game_en`=0; down → GAMEPLAY with no `game_start`; up, up → PAUSED then SONG_SEL, with `game_abort` pulsing once.
- **Idle timeout (TIMEOUT_CYC=10):** in SONG_SEL with no presses → MAIN exactly 10 edges after entry. A press at cycle 9 → stays in SONG_SEL and timer restarts.
- **Async reset mid-game:** assert `rst` between edges during GAMEPLAY → `game_en`=0 and `state`=MAIN before the next edge, with indices cleared to 0.
